edge_level_gen_rnm: RTL

//   RNM level generator; the transmit-side counterpart of the edge detector.
//   It takes rising/falling request pulses and drives a real-valued line

---
 rtl/edge_level_gen_rnm.sv | 127 ++++++++++++
 1 files changed

// File: rtl/edge_level_gen_rnm.sv
// Real-number-model level generator: turns rise/fall request pulses into a
// linearly slewed real line level between V_LOW and V_HIGH, with done and
// conflict pulses. The level is decoded from an integer position so that
// the end points are exact and no float error accumulates along a ramp.
module edge_level_gen_rnm #(
   parameter real V_LOW       = 0.0,
   parameter real V_HIGH      = 1.0,
   parameter int  RAMP_CYCLES = 4,
   parameter bit  RESET_HIGH  = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic rise_req_i,
   input  logic fall_req_i,
   output real  level_o,
   output logic level_high_o,
   output logic busy_o,
   output logic rise_done_o,
   output logic fall_done_o,
   output logic conflict_o
);

   // A zero-length ramp has no meaningful step size; refuse to elaborate.
   generate
      if (RAMP_CYCLES < 1) begin : g_bad_ramp
         $error("edge_level_gen_rnm: RAMP_CYCLES must be >= 1");
      end
   endgenerate

   localparam int  RC_SAFE = (RAMP_CYCLES < 1) ? 1 : RAMP_CYCLES;
   localparam int  PW      = (RC_SAFE < 2) ? 1 : $clog2(RC_SAFE + 1);
   localparam real STEP    = (V_HIGH - V_LOW) / real'(RC_SAFE);

   localparam logic [PW-1:0] POS_MAX = PW'(RC_SAFE);
   localparam logic [PW-1:0] POS_ONE = PW'(1);

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_RAMP_UP   = 2'd1,
      S_HIGH      = 2'd2,
      S_RAMP_DOWN = 2'd3
   } state_t;

   localparam state_t        RST_STATE = RESET_HIGH ? S_HIGH : S_LOW;
   localparam logic [PW-1:0] RST_POS   = RESET_HIGH ? POS_MAX : '0;

   state_t        state, state_n;
   logic [PW-1:0] pos, pos_n;
   logic          rise_done_n, fall_done_n, conflict_n;
   logic          step_up, step_dn, both;

   // State, position and pulse registers; reset aborts any ramp at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RST_STATE;
         pos         <= RST_POS;
         rise_done_o <= 1'b0;
         fall_done_o <= 1'b0;
         conflict_o  <= 1'b0;
      end else begin
         state       <= state_n;
         pos         <= pos_n;
         rise_done_o <= rise_done_n;
         fall_done_o <= fall_done_n;
         conflict_o  <= conflict_n;
      end
   end

   // Next-state: pick a step direction, then settle state from the new pos.
   // Simultaneous requests are dropped but an active ramp keeps moving.
   always_comb begin
      state_n     = state;
      pos_n       = pos;
      rise_done_n = 1'b0;
      fall_done_n = 1'b0;
      both        = rise_req_i & fall_req_i;
      conflict_n  = both;
      step_up     = 1'b0;
      step_dn     = 1'b0;
      case (state)
         S_LOW:       step_up = rise_req_i & ~both;
         S_HIGH:      step_dn = fall_req_i & ~both;
         S_RAMP_UP: begin
            step_dn = fall_req_i & ~both;
            step_up = ~step_dn;
         end
         S_RAMP_DOWN: begin
            step_up = rise_req_i & ~both;
            step_dn = ~step_up;
         end
         default:     state_n = RST_STATE;
      endcase
      if (step_up) begin
         pos_n = pos + POS_ONE;
         if (pos_n == POS_MAX) begin
            state_n     = S_HIGH;
            rise_done_n = 1'b1;
         end else begin
            state_n = S_RAMP_UP;
         end
      end else if (step_dn) begin
         pos_n = pos - POS_ONE;
         if (pos_n == '0) begin
            state_n     = S_LOW;
            fall_done_n = 1'b1;
         end else begin
            state_n = S_RAMP_DOWN;
         end
      end
   end

   // Level decode from the registered position; end points are exact.
   always_comb begin
      level_o = V_LOW + real'(pos) * STEP;
      if (pos == '0)
         level_o = V_LOW;
      else if (pos == POS_MAX)
         level_o = V_HIGH;
   end

   // Status flags decoded purely from the state register.
   always_comb begin
      level_high_o = (state == S_HIGH);
      busy_o       = (state == S_RAMP_UP) || (state == S_RAMP_DOWN);
   end

endmodule
